fir_feed_scheduler: RTL and testbench

- Front-end scheduler that owns the FIR filter core's input handshake.
- Buffers incoming samples in a small FIFO and latches a full coefficient set.
- Shares the core's single data_ready/load_coeff interface between the sample stream and coefficient reloads, pacing both on the core's modwait.
- Sits between the bus-side register block and fir_filter.

---
 rtl/fir_feed_if.sv | 37 +++
 rtl/fir_feed_scheduler.sv | 161 ++++++++++++++++
 tb/tb_fir_feed_scheduler.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fir_feed_if.sv
// Bus-side and core-side signals for fir_feed_scheduler.
// The scheduler uses the slave modport; the register block and core model use master.
interface fir_feed_if #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned NCOEF = 4
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [15:0]         sample_in;
  logic                sample_wr;
  logic                sample_full;
  logic [CW-1:0]       sample_count;
  logic [16*NCOEF-1:0] coeff_set;
  logic                coeff_wr;
  logic                coeff_busy;
  logic                coeff_done;
  logic [15:0]         sample_data;
  logic [15:0]         fir_coefficient;
  logic                data_ready;
  logic                load_coeff;
  logic                modwait;
  logic                overrun;
  logic                ack_err;
  logic [15:0]         feed_cnt;

  modport master (
    output sample_in, sample_wr, coeff_set, coeff_wr, modwait,
    input  sample_full, sample_count, coeff_busy, coeff_done, sample_data,
           fir_coefficient, data_ready, load_coeff, overrun, ack_err, feed_cnt
  );

  modport slave (
    input  sample_in, sample_wr, coeff_set, coeff_wr, modwait,
    output sample_full, sample_count, coeff_busy, coeff_done, sample_data,
           fir_coefficient, data_ready, load_coeff, overrun, ack_err, feed_cnt
  );
endinterface

// File: rtl/fir_feed_scheduler.sv
// Sample FIFO plus coefficient latch sharing the FIR core's strobe interface, paced on modwait.
// Define FIR_FEED_STATS_EN to count completed samples on feed_cnt (tied to 0 otherwise).
module fir_feed_scheduler #(
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned NCOEF       = 4,
  parameter int unsigned ACK_TIMEOUT = 8
) (
  input  logic      clk,
  input  logic      rst,
  fir_feed_if.slave bus
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam int unsigned IW = (NCOEF > 1) ? $clog2(NCOEF) : 1;
  localparam int unsigned TW = $clog2(ACK_TIMEOUT + 1);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] SAMP_STB  = 3'd1;
  localparam logic [2:0] COEF_STB  = 3'd2;
  localparam logic [2:0] WAIT_ACK  = 3'd3;
  localparam logic [2:0] WAIT_DONE = 3'd4;

  logic [2:0]          state, state_next;
  logic [15:0]         mem [DEPTH];
  logic [AW-1:0]       wr_ptr, rd_ptr;
  logic [CW-1:0]       count_next;
  logic [16*NCOEF-1:0] coef_latch;
  logic [IW-1:0]       coef_idx, coef_idx_next;
  logic [TW-1:0]       ack_timer;
  logic                item_coef;
  logic                push, pop, drop, latch_coef;
  logic                timeout, set_done, set_abort;

  // FIFO and latch handshake; a push into a full FIFO survives only if this cycle pops
  always_comb begin
    pop        = (state == SAMP_STB);
    push       = bus.sample_wr && (!bus.sample_full || pop);
    drop       = bus.sample_wr && bus.sample_full && !pop;
    count_next = bus.sample_count + CW'(push) - CW'(pop);
    latch_coef = bus.coeff_wr && !bus.coeff_busy;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Arbitration and item sequencing; a pending coefficient set always wins over samples
  always_comb begin
    state_next    = state;
    coef_idx_next = coef_idx;
    timeout       = 1'b0;
    set_done      = 1'b0;
    set_abort     = 1'b0;
    case (state)
      IDLE: begin
        if (bus.coeff_busy)                                 state_next = COEF_STB;
        else if (bus.sample_count != '0 && !bus.modwait)    state_next = SAMP_STB;
      end
      SAMP_STB, COEF_STB: state_next = WAIT_ACK;
      WAIT_ACK: begin
        if (bus.modwait) begin
          state_next = WAIT_DONE;
        end else if (ack_timer == TW'(ACK_TIMEOUT - 1)) begin
          timeout    = 1'b1;
          state_next = IDLE;
          if (item_coef) begin
            set_abort     = 1'b1;
            coef_idx_next = '0;
          end
        end
      end
      WAIT_DONE: begin
        if (!bus.modwait) begin
          if (!item_coef) begin
            state_next = IDLE;
          end else if (coef_idx == IW'(NCOEF - 1)) begin
            set_done      = 1'b1;
            coef_idx_next = '0;
            state_next    = IDLE;
          end else begin
            coef_idx_next = coef_idx + IW'(1);
            state_next    = COEF_STB;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.sample_in;
  end

  // Registered datapath and outputs; strobes are decoded from the next state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr              <= '0;
      rd_ptr              <= '0;
      coef_latch          <= '0;
      coef_idx            <= '0;
      ack_timer           <= '0;
      item_coef           <= 1'b0;
      bus.sample_count    <= '0;
      bus.sample_full     <= 1'b0;
      bus.coeff_busy      <= 1'b0;
      bus.coeff_done      <= 1'b0;
      bus.sample_data     <= '0;
      bus.fir_coefficient <= '0;
      bus.data_ready      <= 1'b0;
      bus.load_coeff      <= 1'b0;
      bus.overrun         <= 1'b0;
      bus.ack_err         <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      bus.sample_count <= count_next;
      bus.sample_full  <= (count_next == CW'(DEPTH));
      bus.overrun      <= drop;

      if (latch_coef) begin
        coef_latch     <= bus.coeff_set;
        bus.coeff_busy <= 1'b1;
      end else if (set_done || set_abort) begin
        bus.coeff_busy <= 1'b0;
      end
      coef_idx       <= coef_idx_next;
      bus.coeff_done <= set_done;
      bus.ack_err    <= timeout;

      if (state == WAIT_ACK && !bus.modwait) ack_timer <= ack_timer + TW'(1);
      else                                   ack_timer <= '0;

      bus.data_ready <= (state_next == SAMP_STB);
      bus.load_coeff <= (state_next == COEF_STB);
      if (state_next == SAMP_STB) begin
        item_coef       <= 1'b0;
        bus.sample_data <= mem[rd_ptr];
      end
      if (state_next == COEF_STB) begin
        item_coef           <= 1'b1;
        bus.fir_coefficient <= coef_latch[16*coef_idx_next +: 16];
      end
    end
  end

`ifdef FIR_FEED_STATS_EN
  // Completed (acknowledged and released) samples, saturating
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.feed_cnt <= '0;
    end else if (state == WAIT_DONE && !bus.modwait && !item_coef &&
                 bus.feed_cnt != 16'hFFFF) begin
      bus.feed_cnt <= bus.feed_cnt + 16'd1;
    end
  end
`else
  assign bus.feed_cnt = '0;
`endif

endmodule

// File: tb/tb_fir_feed_scheduler.sv
// Self-checking bench for fir_feed_scheduler: core model, strobe scoreboard, vector table
// for FIFO fill/overrun and directed sequences for coefficient load, timeout and reset.
module tb_fir_feed_scheduler;
  localparam int unsigned DEPTH       = 4;
  localparam int unsigned NCOEF       = 4;
  localparam int unsigned ACK_TIMEOUT = 8;
  localparam int          BUSY        = 5;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fir_feed_if #(.DEPTH(DEPTH), .NCOEF(NCOEF)) bus ();

  fir_feed_scheduler #(.DEPTH(DEPTH), .NCOEF(NCOEF), .ACK_TIMEOUT(ACK_TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  logic [15:0] samp_q[$];
  logic [15:0] coef_q[$];
  logic hold_busy   = 1'b0;
  logic core_ack    = 1'b1;
  logic start_pend  = 1'b0;
  logic coef_expect = 1'b0;
  int   busy_left   = 0;
  int   dr_cyc = -1, ack_cyc = -1, done_cyc = -1;
  int   dr_n = 0, lc_n = 0, ack_n = 0, done_n = 0;

  typedef struct {
    logic        wr;
    logic [15:0] d;
    logic        acc;
    logic [2:0]  cnt;
    logic        full;
    logic        ovr;
  } vec_t;
  vec_t vt[6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [15:0] d, input logic accept);
    bus.sample_in = d;
    bus.sample_wr = 1'b1;
    if (accept) samp_q.push_back(d);
    tick();
    bus.sample_wr = 1'b0;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 300 && !(samp_q.size() == 0 && bus.sample_count == '0); i++) tick();
    check(name, 64'(samp_q.size()), 64'd0);
    tick(10);
  endtask

  task automatic check_all_zero(input string pfx);
    check({pfx, "_ctrl"}, 64'({bus.data_ready, bus.load_coeff, bus.sample_full, bus.coeff_busy,
                              bus.coeff_done, bus.overrun, bus.ack_err}), 64'd0);
    check({pfx, "_data"}, 64'({bus.sample_count, bus.sample_data, bus.fir_coefficient,
                              bus.feed_cnt}), 64'd0);
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Core model: modwait rises the cycle after a strobe and stays high for BUSY cycles
  initial begin
    bus.modwait = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        bus.modwait = 1'b0;
        busy_left   = 0;
        start_pend  = 1'b0;
      end else begin
        if (hold_busy) begin
          bus.modwait = 1'b1;
        end else if (busy_left > 0) begin
          busy_left--;
          if (busy_left == 0) bus.modwait = 1'b0;
        end else if (start_pend) begin
          start_pend  = 1'b0;
          bus.modwait = 1'b1;
          busy_left   = BUSY;
        end else begin
          bus.modwait = 1'b0;
        end
        if (core_ack && (bus.data_ready || bus.load_coeff)) start_pend = 1'b1;
      end
    end
  end

  // Strobe monitor and scoreboard
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      if (bus.data_ready) begin
        dr_n++;
        dr_cyc = cyc;
        check("no_data_ready_during_coef_set", 64'(coef_expect), 64'd0);
        check("data_ready_expected", 64'(samp_q.size() != 0), 64'd1);
        if (samp_q.size() != 0) check("sample_data", 64'(bus.sample_data), 64'(samp_q.pop_front()));
      end
      if (bus.load_coeff) begin
        lc_n++;
        check("load_coeff_expected", 64'(coef_q.size() != 0), 64'd1);
        if (coef_q.size() != 0) check("fir_coefficient", 64'(bus.fir_coefficient), 64'(coef_q.pop_front()));
      end
      if (bus.coeff_done) begin
        done_n++;
        done_cyc    = cyc;
        coef_expect = 1'b0;
      end
      if (bus.ack_err) begin
        ack_n++;
        ack_cyc = cyc;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0, base, exp_feed;
    bus.sample_in = '0;
    bus.sample_wr = 1'b0;
    bus.coeff_set = '0;
    bus.coeff_wr  = 1'b0;
    rst = 1'b1;
    tick(3);
    check_all_zero("reset");
    rst = 1'b0;

    // Single sample latency
    n0 = cyc;
    push(16'h0012, 1'b1);
    check("t1_count_after_push", 64'(bus.sample_count), 64'd1);
    for (int i = 0; i < 20 && dr_n < 1; i++) tick();
    check("t1_latency", 64'(dr_cyc - n0), 64'd2);
    drain("t1_drain");
    check("t1_single_strobe", 64'(dr_n), 64'd1);
    check("t1_count_zero", 64'(bus.sample_count), 64'd0);

    // FIFO fill and overrun with the core held busy
    vt[0] = '{1'b1, 16'h00A0, 1'b1, 3'd1, 1'b0, 1'b0};
    vt[1] = '{1'b1, 16'h00A1, 1'b1, 3'd2, 1'b0, 1'b0};
    vt[2] = '{1'b1, 16'h00A2, 1'b1, 3'd3, 1'b0, 1'b0};
    vt[3] = '{1'b1, 16'h00A3, 1'b1, 3'd4, 1'b1, 1'b0};
    vt[4] = '{1'b1, 16'h00A4, 1'b0, 3'd4, 1'b1, 1'b1};
    vt[5] = '{1'b0, 16'h0000, 1'b0, 3'd4, 1'b1, 1'b0};
    hold_busy = 1'b1;
    tick(2);
    for (int i = 0; i < 6; i++) begin
      bus.sample_in = vt[i].d;
      bus.sample_wr = vt[i].wr;
      if (vt[i].acc) samp_q.push_back(vt[i].d);
      tick();
      bus.sample_wr = 1'b0;
      check($sformatf("t2_count_%0d", i), 64'(bus.sample_count), 64'(vt[i].cnt));
      check($sformatf("t2_full_%0d", i), 64'(bus.sample_full), 64'(vt[i].full));
      check($sformatf("t2_overrun_%0d", i), 64'(bus.overrun), 64'(vt[i].ovr));
    end
    hold_busy = 1'b0;
    // Push while full in the pop cycle: both accepted, occupancy unchanged
    for (int i = 0; i < 20 && !bus.data_ready; i++) tick();
    push(16'h00E4, 1'b1);
    check("t2_simul_count", 64'(bus.sample_count), 64'd4);
    check("t2_simul_no_overrun", 64'(bus.overrun), 64'd0);
    drain("t2_drain");

    // Coefficient load pre-empts queued samples but not the one in flight
    base = done_n;
    push(16'h00B0, 1'b1);
    push(16'h00B1, 1'b1);
    push(16'h00B2, 1'b1);
    for (int k = 1; k <= 4; k++) coef_q.push_back(16'(k));
    coef_expect   = 1'b1;
    bus.coeff_set = {16'd4, 16'd3, 16'd2, 16'd1};
    bus.coeff_wr  = 1'b1;
    tick();
    bus.coeff_wr = 1'b0;
    check("t3_busy_set", 64'(bus.coeff_busy), 64'd1);
    bus.coeff_set = {16'd9, 16'd9, 16'd9, 16'd9};
    bus.coeff_wr  = 1'b1;
    tick();
    bus.coeff_wr = 1'b0;
    for (int i = 0; i < 300 && done_n == base; i++) tick();
    check("t3_busy_clear", 64'(bus.coeff_busy), 64'd0);
    drain("t3_drain");
    check("t3_done_once", 64'(done_n - base), 64'd1);
    check("t3_coef_all_loaded", 64'(coef_q.size()), 64'd0);
    check("t3_samples_after_done", 64'(dr_cyc > done_cyc), 64'd1);

    // Acknowledge timeout
    base     = ack_n;
    core_ack = 1'b0;
    push(16'h00D0, 1'b1);
    for (int i = 0; i < 40 && ack_n == base; i++) tick();
    check("t4_ack_err_delay", 64'(ack_cyc - dr_cyc), 64'(ACK_TIMEOUT + 1));
    tick(3);
    check("t4_ack_err_once", 64'(ack_n - base), 64'd1);
    core_ack = 1'b1;
    push(16'h00D1, 1'b1);
    drain("t4_recover");

    // Asynchronous reset during WAIT_DONE of coefficient 2
    base = lc_n;
    for (int k = 5; k <= 8; k++) coef_q.push_back(16'(k));
    coef_expect   = 1'b1;
    bus.coeff_set = {16'd8, 16'd7, 16'd6, 16'd5};
    bus.coeff_wr  = 1'b1;
    push(16'h00F0, 1'b0);
    bus.coeff_wr = 1'b0;
    push(16'h00F1, 1'b0);
    for (int i = 0; i < 100 && lc_n < base + 3; i++) tick();
    check("t5_third_coef_seen", 64'(lc_n - base), 64'd3);
    tick(2);
    #3;
    rst = 1'b1;
    #1;
    check_all_zero("t5_async_reset");
    coef_q.delete();
    samp_q.delete();
    coef_expect = 1'b0;
    tick(2);
    rst = 1'b0;
    tick(2);
    check("t5_busy_after", 64'(bus.coeff_busy), 64'd0);
    check("t5_count_after", 64'(bus.sample_count), 64'd0);
    base = done_n;
    for (int k = 9; k <= 12; k++) coef_q.push_back(16'(k));
    coef_expect   = 1'b1;
    bus.coeff_set = {16'd12, 16'd11, 16'd10, 16'd9};
    bus.coeff_wr  = 1'b1;
    tick();
    bus.coeff_wr = 1'b0;
    for (int i = 0; i < 300 && done_n == base; i++) tick();
    check("t5_restart_done", 64'(done_n - base), 64'd1);
    check("t5_restart_all_loaded", 64'(coef_q.size()), 64'd0);

    // Delivered-sample counter: 3 completed, 1 timed out
    push(16'h0C00, 1'b1);
    push(16'h0C01, 1'b1);
    push(16'h0C02, 1'b1);
    drain("t6_drain");
    base     = ack_n;
    core_ack = 1'b0;
    push(16'h0C03, 1'b1);
    for (int i = 0; i < 40 && ack_n == base; i++) tick();
    check("t6_timeout_seen", 64'(ack_n - base), 64'd1);
    core_ack = 1'b1;
    tick(2);
`ifdef FIR_FEED_STATS_EN
    exp_feed = 3;
`else
    exp_feed = 0;
`endif
    check("t6_feed_cnt", 64'(bus.feed_cnt), 64'(exp_feed));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
